// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
//   Shared definitions for the RAM port arbiter and its round-robin picker:
//   FSM state encoding, requester IDs and the RAM strobe active levels.
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

  // Access FSM. Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  // Requester IDs; also the bit positions in the picker's request vector.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // RAM strobes are active-low.
  localparam logic RAM_STROBE_ON  = 1'b0;
  localparam logic RAM_STROBE_OFF = 1'b1;

  // Map an "asserted" flag onto the RAM strobe level.
  function automatic logic ram_strobe(input logic active);
    return active ? RAM_STROBE_ON : RAM_STROBE_OFF;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational 2-way round-robin picker.
//   Ports:
//     req[1:0]  in   request vector, bit index = requester ID
//     last      in   ID that received the previous grant
//     gnt_id    out  ID of the winner (meaningful only when any=1)
//     any       out  at least one request present
//   A lone requester always wins; on a tie the requester that was not granted
//   last time wins.
// ---------------------------------------------------------------------------
import ram_port_arbiter_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    gnt_id = REQ_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[REQ_LDR]) begin
      gnt_id = REQ_LDR;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares the single-port program/data RAM between the CPU control path and
//   the external program loader. Each requester uses a req/gnt/rvalid
//   handshake; the arbiter drives the RAM's active-low strobes and steers the
//   read data back to the requester that owns the access.
//
//   Timing (edge N = IDLE edge that samples the requests):
//     after N   : gnt pulse, ram_ce_n=0, ram_we_n=!we, addr/wdata driven
//     after N+1 : strobes released; write done (IDLE), read goes to RDWAIT
//     after N+2 : read data captured, rvalid pulse, back in IDLE
//
//   Parameters: ADDR_W (RAM address width), DATA_W (RAM data width)
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     cpu_req/we/addr/wdata         CPU request side (inputs)
//     cpu_gnt/rvalid/rdata          CPU response side (registered outputs)
//     ldr_req/we/addr/wdata         loader request side (inputs)
//     ldr_gnt/rvalid/rdata          loader response side (registered outputs)
//     cpu_halt                      CPU halted; gates the loader when
//                                   RAM_ARB_LOADER_LOCK_EN is defined
//     ram_ce_n/we_n/addr/wdata      RAM macro controls (registered outputs)
//     ram_rdata                     RAM read data (1 cycle after ce_n low)
//     busy                          registered, high whenever not IDLE
//
//   Build option: RAM_ARB_LOADER_LOCK_EN -- when defined, a loader request is
//   only eligible while cpu_halt=1; a blocked request simply stays pending.
//   When undefined, cpu_halt is ignored and arbitration is plain round-robin.
// ---------------------------------------------------------------------------
import ram_port_arbiter_pkg::*;

module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader port
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  // CPU status
  input  logic              cpu_halt,
  // RAM macro
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // Status
  output logic              busy
);

  arb_state_t        state_reg, state_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic              we_reg;
  logic              cpu_gnt_reg, ldr_gnt_reg;
  logic              ram_ce_n_reg, ram_we_n_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic              busy_reg;

  // -------------------------------------------------------------------------
  // Eligibility and arbitration
  // -------------------------------------------------------------------------
  logic ldr_eligible;

`ifdef RAM_ARB_LOADER_LOCK_EN
  // The loader may only touch RAM while the CPU sits in HLT.
  assign ldr_eligible = ldr_req & cpu_halt;
`else
  logic cpu_halt_unused;
  assign cpu_halt_unused = cpu_halt;
  assign ldr_eligible    = ldr_req;
`endif

  logic [1:0] pick_req;
  logic       pick_id;
  logic       pick_any;

  assign pick_req[REQ_CPU] = cpu_req;
  assign pick_req[REQ_LDR] = ldr_eligible;

  rr_arb2 u_pick (
    .req    (pick_req),
    .last   (last_grant_reg),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Winner's access fields, captured on the IDLE edge.
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              start_access;

  assign sel_we       = (pick_id == REQ_LDR) ? ldr_we    : cpu_we;
  assign sel_addr     = (pick_id == REQ_LDR) ? ldr_addr  : cpu_addr;
  assign sel_wdata    = (pick_id == REQ_LDR) ? ldr_wdata : cpu_wdata;
  assign start_access = (state_reg == IDLE) && pick_any;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = ACCESS;
      ACCESS:  state_next = we_reg ? IDLE : RDWAIT;
      RDWAIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, capture and RAM-side output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= REQ_LDR;  // makes the first tie go to the CPU
      owner_reg      <= REQ_CPU;
      we_reg         <= 1'b0;
      cpu_gnt_reg    <= 1'b0;
      ldr_gnt_reg    <= 1'b0;
      ram_ce_n_reg   <= RAM_STROBE_OFF;
      ram_we_n_reg   <= RAM_STROBE_OFF;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != IDLE);
      // Strobes and grants are single-cycle; addr/wdata hold while idle.
      cpu_gnt_reg  <= 1'b0;
      ldr_gnt_reg  <= 1'b0;
      ram_ce_n_reg <= RAM_STROBE_OFF;
      ram_we_n_reg <= RAM_STROBE_OFF;
      if (start_access) begin
        owner_reg      <= pick_id;
        last_grant_reg <= pick_id;
        we_reg         <= sel_we;
        ram_addr_reg   <= sel_addr;
        ram_wdata_reg  <= sel_wdata;
        ram_ce_n_reg   <= ram_strobe(1'b1);
        ram_we_n_reg   <= ram_strobe(sel_we);
        cpu_gnt_reg    <= (pick_id == REQ_CPU);
        ldr_gnt_reg    <= (pick_id == REQ_LDR);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-requester read-return registers. Only the owner of the access in
  // RDWAIT updates; the other side's rdata/rvalid are left alone.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;
      logic              rvalid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= 1'b0;
          if ((state_reg == RDWAIT) && (owner_reg == 1'(gi))) begin
            rdata_reg  <= ram_rdata;
            rvalid_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // g_port[0] serves the CPU (REQ_CPU), g_port[1] the loader (REQ_LDR).
  assign cpu_rdata  = g_port[0].rdata_reg;
  assign cpu_rvalid = g_port[0].rvalid_reg;
  assign ldr_rdata  = g_port[1].rdata_reg;
  assign ldr_rvalid = g_port[1].rvalid_reg;

  assign cpu_gnt   = cpu_gnt_reg;
  assign ldr_gnt   = ldr_gnt_reg;
  assign ram_ce_n  = ram_ce_n_reg;
  assign ram_we_n  = ram_we_n_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Directed testbench for ram_port_arbiter with a synchronous 16x8 RAM model.
//   Inputs change 1 ns after the rising edge; outputs are checked at that
//   point, i.e. they show the registered values produced by the last edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [3:0] ldr_addr = 4'h0;
  logic [7:0] ldr_wdata = 8'h00;
  logic       ldr_gnt, ldr_rvalid;
  logic [7:0] ldr_rdata;
  logic       cpu_halt = 1'b0;
  logic       ram_ce_n, ram_we_n;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int ce_low_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .cpu_halt   (cpu_halt),
    .ram_ce_n   (ram_ce_n),
    .ram_we_n   (ram_we_n),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  // Synchronous single-port RAM: registered read one cycle after ce_n low.
  logic [7:0] mem [16] = '{5: 8'h5A, default: 8'h00};

  always @(posedge clk) begin
    if (!ram_ce_n) begin
      if (!ram_we_n) mem[ram_addr] <= ram_wdata;
      else           ram_rdata     <= mem[ram_addr];
    end
  end

  // One line per transaction.
  always @(negedge clk) begin
    if (cpu_gnt)    $display("%0t cpu grant  we=%0b addr=%h wdata=%h", $time, !ram_we_n, ram_addr, ram_wdata);
    if (ldr_gnt)    $display("%0t ldr grant  we=%0b addr=%h wdata=%h", $time, !ram_we_n, ram_addr, ram_wdata);
    if (cpu_rvalid) $display("%0t cpu rvalid rdata=%h", $time, cpu_rdata);
    if (ldr_rvalid) $display("%0t ldr rvalid rdata=%h", $time, ldr_rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_count;
    tick();
    if (ram_ce_n == 1'b0) ce_low_cnt++;
  endtask

  // 1: reset holds everything off even with a pending request
  task automatic test_reset;
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (cpu_gnt !== 1'b0)  $display("FAIL reset_gnt: got %b want 0", cpu_gnt);
      if (cpu_gnt !== 1'b0) errors++;
      checks++; if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n: got %b want 1", ram_ce_n); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    rst = 1'b0;
    tick();
    checks++; if (cpu_gnt !== 1'b1)  begin errors++; $display("FAIL post_reset_gnt: got %b want 1", cpu_gnt); end
    checks++; if (ram_ce_n !== 1'b0) begin errors++; $display("FAIL post_reset_ce_n: got %b want 0", ram_ce_n); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL post_reset_busy: got %b want 1", busy); end
    cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  // 2: CPU write then read of the same address
  task automatic test_write_read;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
    tick();
    checks++; if (cpu_gnt !== 1'b1)   begin errors++; $display("FAIL wr_gnt: got %b want 1", cpu_gnt); end
    checks++; if (ram_we_n !== 1'b0)  begin errors++; $display("FAIL wr_we_n: got %b want 0", ram_we_n); end
    checks++; if (ram_addr !== 4'h3)  begin errors++; $display("FAIL wr_addr: got %h want 3", ram_addr); end
    checks++; if (ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_wdata: got %h want a5", ram_wdata); end
    cpu_req = 1'b0;
    tick();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL wr_done_busy: got %b want 0", busy); end
    checks++; if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL wr_done_ce_n: got %b want 1", ram_ce_n); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    tick();
    checks++; if (cpu_gnt !== 1'b1)  begin errors++; $display("FAIL rd_gnt: got %b want 1", cpu_gnt); end
    checks++; if (ram_we_n !== 1'b1) begin errors++; $display("FAIL rd_we_n: got %b want 1", ram_we_n); end
    cpu_req = 1'b0;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b want 0", cpu_rvalid); end
    tick();
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", cpu_rdata); end
    checks++; if (ldr_rdata !== 8'h00) begin errors++; $display("FAIL rd_ldr_untouched: got %h want 00", ldr_rdata); end
    checks++; if (ldr_rvalid !== 1'b0) begin errors++; $display("FAIL rd_ldr_rvalid: got %b want 0", ldr_rvalid); end
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data_hold: got %h want a5", cpu_rdata); end
  endtask

  // 3: both request reads after reset -> CPU, LDR, CPU, LDR
  task automatic test_round_robin;
    int waited;
    logic [1:0] exp_gnt;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h5;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(cpu_gnt || ldr_gnt) && waited < 10);
      exp_gnt = (g % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if ({ldr_gnt, cpu_gnt} !== exp_gnt) begin
        errors++;
        $display("FAIL rr_order[%0d]: got {ldr,cpu}=%b want %b", g, {ldr_gnt, cpu_gnt}, exp_gnt);
      end
      if (g > 0) begin
        checks++;
        if (waited !== 2) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d idle ticks want 2", g, waited);
        end
      end
      if (cpu_gnt) begin
        cpu_req = 1'b0; tick(); cpu_req = 1'b1;
      end else if (ldr_gnt) begin
        ldr_req = 1'b0; tick(); ldr_req = 1'b1;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (4) tick();
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rr_cpu_data: got %h want a5", cpu_rdata); end
    checks++; if (ldr_rdata !== 8'h5A) begin errors++; $display("FAIL rr_ldr_data: got %h want 5a", ldr_rdata); end
  endtask

  // 4: loader write, CPU read queued behind it
  task automatic test_ldr_then_cpu;
    ce_low_cnt = 0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h3C;
    tick_count();
    checks++; if (ldr_gnt !== 1'b1)  begin errors++; $display("FAIL lw_gnt: got %b want 1", ldr_gnt); end
    checks++; if (ram_we_n !== 1'b0) begin errors++; $display("FAIL lw_we_n: got %b want 0", ram_we_n); end
    ldr_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hF;
    tick_count();
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL q_no_early_gnt: got %b want 0", cpu_gnt); end
    tick_count();
    checks++; if (cpu_gnt !== 1'b1)  begin errors++; $display("FAIL q_gnt: got %b want 1", cpu_gnt); end
    checks++; if (ram_addr !== 4'hF) begin errors++; $display("FAIL q_addr: got %h want f", ram_addr); end
    cpu_req = 1'b0;
    tick_count();
    tick_count();
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL q_rvalid: got %b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 8'h3C) begin errors++; $display("FAIL q_data: got %h want 3c", cpu_rdata); end
    tick_count();
    checks++; if (ce_low_cnt !== 2) begin errors++; $display("FAIL q_ce_cycles: got %0d want 2", ce_low_cnt); end
  endtask

  // 5: reset during RDWAIT aborts the read
  task automatic test_reset_mid_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    tick();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt: got %b want 1", cpu_gnt); end
    cpu_req = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_rdwait_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata: got %h want 00", cpu_rdata); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL abort_late_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (ram_ce_n !== 1'b1)   begin errors++; $display("FAIL abort_ce_n: got %b want 1", ram_ce_n); end
  endtask

  // 6: loader lock on cpu_halt (or plain immediate grant without the option)
  task automatic test_loader_lock;
    int gnt_seen;
    int waited;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h5; cpu_halt = 1'b0;
`ifdef RAM_ARB_LOADER_LOCK_EN
    gnt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ldr_gnt) gnt_seen++;
    end
    checks++; if (gnt_seen !== 0) begin errors++; $display("FAIL lock_blocked: got %0d grants want 0", gnt_seen); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL lock_busy: got %b want 0", busy); end
    cpu_halt = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!ldr_gnt && waited < 4);
    checks++; if (ldr_gnt !== 1'b1) begin errors++; $display("FAIL lock_release_gnt: got %b want 1", ldr_gnt); end
    checks++; if (waited > 2)       begin errors++; $display("FAIL lock_release_delay: got %0d ticks want <=2", waited); end
`else
    gnt_seen = 0;
    waited = 0;
    tick();
    if (ldr_gnt) gnt_seen++;
    waited++;
    checks++; if (ldr_gnt !== 1'b1) begin errors++; $display("FAIL nolock_gnt: got %b want 1", ldr_gnt); end
    checks++; if (gnt_seen !== waited) begin errors++; $display("FAIL nolock_first_cycle: got %0d want %0d", gnt_seen, waited); end
`endif
    ldr_req = 1'b0;
    tick(); tick();
    checks++; if (ldr_rvalid !== 1'b1) begin errors++; $display("FAIL lock_rvalid: got %b want 1", ldr_rvalid); end
    checks++; if (ldr_rdata !== 8'h5A) begin errors++; $display("FAIL lock_rdata: got %h want 5a", ldr_rdata); end
    cpu_halt = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_ldr_then_cpu();
    test_reset_mid_read();
    test_loader_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
